ssd_byte_demux: RTL and testbench

//  Receive-side counterpart of the SSD byte multiplexer: reassembles a byte-serial

---
 rtl/ssd_byte_demux.sv | 89 ++++++++
 tb/tb_ssd_byte_demux.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ssd_byte_demux.sv
// ssd_byte_demux: reassembles a sync-flagged byte-serial stream into full words,
// tracking frame alignment and counting framing errors.
module ssd_byte_demux #(
    parameter int NUM_LANES = 4,
    parameter int LANE_W    = 8,
    parameter int ERR_W     = 8
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        IN_VALID,
    input  logic                        IN_SYNC,
    input  logic [LANE_W-1:0]           INPUT,
    output logic [NUM_LANES*LANE_W-1:0] OUTPUT,
    output logic                        OUT_VALID,
    output logic                        LOCKED,
    output logic                        SYNC_ERR,
    output logic [ERR_W-1:0]            ERR_CNT
);
    localparam int W  = NUM_LANES * LANE_W;
    localparam int CW = NUM_LANES > 1 ? $clog2(NUM_LANES) : 1;
    typedef enum logic [1:0] {HUNT, COLLECT, ALIGNED} state_t;
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [W-1:0] part, part_n, out_n;
    logic ov_n, err_n;
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= HUNT;
            cnt       <= '0;
            part      <= '0;
            OUTPUT    <= '0;
            OUT_VALID <= 1'b0;
            SYNC_ERR  <= 1'b0;
            ERR_CNT   <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            part      <= part_n;
            OUTPUT    <= out_n;
            OUT_VALID <= ov_n;
            SYNC_ERR  <= err_n;
            if (err_n && ERR_CNT != '1)
                ERR_CNT <= ERR_CNT + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        part_n  = part;
        out_n   = OUTPUT;
        ov_n    = 1'b0;
        err_n   = 1'b0;
        if (IN_VALID) begin
            case (state)
                HUNT: if (IN_SYNC) begin
                    part_n  = W'(INPUT);
                    cnt_n   = CW'(1);
                    state_n = COLLECT;
                end
                COLLECT: if (IN_SYNC) begin
                    // Re-frame on the new sync byte; the partial word is abandoned.
                    err_n  = 1'b1;
                    part_n = W'(INPUT);
                    cnt_n  = CW'(1);
                end else begin
                    part_n[LANE_W*cnt +: LANE_W] = INPUT;
                    if (cnt == CW'(NUM_LANES - 1)) begin
                        out_n   = part_n;
                        ov_n    = 1'b1;
                        cnt_n   = '0;
                        state_n = ALIGNED;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                ALIGNED: if (IN_SYNC) begin
                    part_n  = W'(INPUT);
                    cnt_n   = CW'(1);
                    state_n = COLLECT;
                end else begin
                    err_n   = 1'b1;
                    state_n = HUNT;
                end
                default: state_n = HUNT;
            endcase
        end
    end
    assign LOCKED = state != HUNT;
endmodule

// File: tb/tb_ssd_byte_demux.sv
// tb_ssd_byte_demux: table vectors, hand-written corner sequences and a
// queue-based reference model driven by random framed traffic.
module tb_ssd_byte_demux;
    logic CLK = 1'b0, RST_N = 1'b0, IN_VALID = 1'b0, IN_SYNC = 1'b0;
    logic [7:0] INPUT = 8'h00;
    logic [31:0] OUTPUT;
    logic OUT_VALID, LOCKED, SYNC_ERR;
    logic [7:0] ERR_CNT;
    int checks = 0, errors = 0;

    ssd_byte_demux dut (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_SYNC(IN_SYNC), .INPUT(INPUT),
        .OUTPUT(OUTPUT), .OUT_VALID(OUT_VALID), .LOCKED(LOCKED), .SYNC_ERR(SYNC_ERR),
        .ERR_CNT(ERR_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic v, s;
        logic [7:0] d;
        logic ov;
        logic [31:0] o;
        logic lk, er;
        logic [7:0] ec;
    } vec_t;
    vec_t tv[14];

    // Reference model: bytes of the frame in progress plus "just completed a frame".
    logic [7:0] q[$];
    logic m_al = 1'b0, m_ov = 1'b0, m_err = 1'b0;
    logic [31:0] m_out = 32'h0;
    logic [7:0] m_ec = 8'h0;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_al = 1'b0; m_ov = 1'b0; m_err = 1'b0; m_out = 32'h0; m_ec = 8'h0;
    endtask

    task automatic step(input logic v, input logic s, input logic [7:0] d);
        IN_VALID = v; IN_SYNC = s; INPUT = d;
        m_ov = 1'b0; m_err = 1'b0;
        if (v) begin
            if (q.size() > 0) begin
                if (s) begin
                    m_err = 1'b1;
                    q.delete();
                    q.push_back(d);
                end else begin
                    q.push_back(d);
                    if (q.size() == 4) begin
                        m_out = {q[3], q[2], q[1], q[0]};
                        m_ov = 1'b1;
                        q.delete();
                        m_al = 1'b1;
                    end
                end
            end else if (m_al) begin
                m_al = 1'b0;
                if (s) q.push_back(d);
                else m_err = 1'b1;
            end else if (s) begin
                q.push_back(d);
            end
        end
        if (m_err && m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        @(negedge CLK);
        chk("model OUTPUT", OUTPUT, m_out);
        chk("model OUT_VALID", {31'd0, OUT_VALID}, {31'd0, m_ov});
        chk("model LOCKED", {31'd0, LOCKED}, {31'd0, (q.size() > 0) || m_al});
        chk("model SYNC_ERR", {31'd0, SYNC_ERR}, {31'd0, m_err});
        chk("model ERR_CNT", {24'd0, ERR_CNT}, {24'd0, m_ec});
    endtask

    task automatic all_zero(input string n);
        chk({n, " OUTPUT"}, OUTPUT, 32'h0);
        chk({n, " OUT_VALID"}, {31'd0, OUT_VALID}, 32'd0);
        chk({n, " LOCKED"}, {31'd0, LOCKED}, 32'd0);
        chk({n, " SYNC_ERR"}, {31'd0, SYNC_ERR}, 32'd0);
        chk({n, " ERR_CNT"}, {24'd0, ERR_CNT}, 32'd0);
    endtask

    initial begin
        int pos, pulses;
        logic s;
        // valid, sync, data | out_valid, output, locked, sync_err, err_cnt (after the edge)
        tv[0]  = '{1'b1, 1'b0, 8'hAA, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'd0};
        tv[1]  = '{1'b1, 1'b0, 8'hBB, 1'b0, 32'h00000000, 1'b0, 1'b0, 8'd0};
        tv[2]  = '{1'b1, 1'b1, 8'h11, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'd0};
        tv[3]  = '{1'b1, 1'b0, 8'h22, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'd0};
        tv[4]  = '{1'b1, 1'b0, 8'h33, 1'b0, 32'h00000000, 1'b1, 1'b0, 8'd0};
        tv[5]  = '{1'b1, 1'b0, 8'h44, 1'b1, 32'h44332211, 1'b1, 1'b0, 8'd0};
        tv[6]  = '{1'b1, 1'b1, 8'h01, 1'b0, 32'h44332211, 1'b1, 1'b0, 8'd0};
        tv[7]  = '{1'b1, 1'b0, 8'h02, 1'b0, 32'h44332211, 1'b1, 1'b0, 8'd0};
        tv[8]  = '{1'b1, 1'b1, 8'h10, 1'b0, 32'h44332211, 1'b1, 1'b1, 8'd1};
        tv[9]  = '{1'b1, 1'b0, 8'h20, 1'b0, 32'h44332211, 1'b1, 1'b0, 8'd1};
        tv[10] = '{1'b0, 1'b1, 8'h99, 1'b0, 32'h44332211, 1'b1, 1'b0, 8'd1};
        tv[11] = '{1'b1, 1'b0, 8'h30, 1'b0, 32'h44332211, 1'b1, 1'b0, 8'd1};
        tv[12] = '{1'b1, 1'b0, 8'h40, 1'b1, 32'h40302010, 1'b1, 1'b0, 8'd1};
        tv[13] = '{1'b1, 1'b0, 8'h55, 1'b0, 32'h40302010, 1'b0, 1'b1, 8'd2};

        repeat (2) @(negedge CLK);
        all_zero("reset");
        RST_N = 1'b1;
        foreach (tv[i]) begin
            IN_VALID = tv[i].v; IN_SYNC = tv[i].s; INPUT = tv[i].d;
            @(negedge CLK);
            chk($sformatf("vec%0d OUTPUT", i), OUTPUT, tv[i].o);
            chk($sformatf("vec%0d OUT_VALID", i), {31'd0, OUT_VALID}, {31'd0, tv[i].ov});
            chk($sformatf("vec%0d LOCKED", i), {31'd0, LOCKED}, {31'd0, tv[i].lk});
            chk($sformatf("vec%0d SYNC_ERR", i), {31'd0, SYNC_ERR}, {31'd0, tv[i].er});
            chk($sformatf("vec%0d ERR_CNT", i), {24'd0, ERR_CNT}, {24'd0, tv[i].ec});
        end

        // Error counter saturation: good frame then an unsynced beat, repeated.
        for (int i = 0; i < 260; i++) begin
            for (int k = 0; k < 4; k++) begin
                IN_VALID = 1'b1; IN_SYNC = (k == 0); INPUT = 8'(k + 1);
                @(negedge CLK);
            end
            IN_SYNC = 1'b0; INPUT = 8'h55;
            @(negedge CLK);
            if (i % 37 == 0 || i >= 250) begin
                chk($sformatf("sat%0d SYNC_ERR", i), {31'd0, SYNC_ERR}, 32'd1);
                chk($sformatf("sat%0d ERR_CNT", i), {24'd0, ERR_CNT}, (i + 3 > 255) ? 32'd255 : 32'(i + 3));
            end
        end
        chk("sat LOCKED", {31'd0, LOCKED}, 32'd0);
        chk("sat OUTPUT", OUTPUT, 32'h04030201);

        // Asynchronous reset mid-frame after two beats.
        IN_SYNC = 1'b1; INPUT = 8'hA1; @(negedge CLK);
        IN_SYNC = 1'b0; INPUT = 8'hA2; @(negedge CLK);
        IN_VALID = 1'b0;
        #2 RST_N = 1'b0;
        #1 all_zero("async reset");
        @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        step(1'b1, 1'b0, 8'hA3);
        step(1'b1, 1'b1, 8'hB0); step(1'b1, 1'b0, 8'hB1); step(1'b1, 1'b0, 8'hB2); step(1'b1, 1'b0, 8'hB3);
        chk("post-reset word", OUTPUT, 32'hB3B2B1B0);
        step(1'b0, 1'b0, 8'h00);

        // Three clean frames with 1-3 idle cycles between beats.
        pulses = 0;
        for (int f = 0; f < 3; f++)
            for (int k = 0; k < 4; k++) begin
                step(1'b1, k == 0, 8'($urandom));
                pulses += int'(OUT_VALID);
                repeat ($urandom_range(1, 3)) begin
                    step(1'b0, 1'($urandom), 8'($urandom));
                    pulses += int'(OUT_VALID);
                end
            end
        chk("gapped frames pulses", 32'(pulses), 32'd3);
        chk("gapped frames ERR_CNT", {24'd0, ERR_CNT}, 32'd0);

        // Random framed traffic with occasional gaps and corrupted sync flags.
        pos = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step(1'b0, 1'($urandom), 8'($urandom));
            end else begin
                s = (pos == 0);
                if ($urandom_range(0, 19) == 0) s = ~s;
                step(1'b1, s, 8'($urandom));
                pos = (pos + 1) % 4;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
